// File: rtl/hazard_history_unit.sv
// Two-deep destination history for forwarding, plus load-use stall, branch flush
// and saturating event counters.
module hazard_history_unit #(
  parameter int unsigned LU_STALLS    = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_hold,
  input  logic             dec_valid,
  input  logic             dec_we,
  input  logic             dec_wsel,
  input  logic [1:0]       dec_ra,
  input  logic [1:0]       dec_rb,
  input  logic [2:0]       dec_data_sel,
  input  logic             dec_reads_a,
  input  logic             dec_reads_b,
  input  logic             branch_taken,
  output logic             prev_we,
  output logic             pprev_we,
  output logic             prev_wsel,
  output logic             pprev_wsel,
  output logic [1:0]       prev_waddr,
  output logic [1:0]       pprev_waddr,
  output logic [2:0]       prev_data_sel,
  output logic [2:0]       pprev_data_sel,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LU    = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int unsigned MAXB = (LU_STALLS > FLUSH_CYCLES) ? LU_STALLS : FLUSH_CYCLES;
  localparam int unsigned CW   = (MAXB > 2) ? $clog2(MAXB) : 1;

  // cnt counts the bubbles still owed after the current cycle, so the
  // triggering cycle itself is the first of LU_STALLS / FLUSH_CYCLES bubbles.
  localparam logic [CW-1:0] LU_LOAD = CW'((LU_STALLS > 1) ? LU_STALLS - 2 : 0);
  localparam logic [CW-1:0] FL_LOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  // History entry layout: {we, wsel, waddr[1:0], data_sel[2:0]}
  logic [6:0]       r_prev;
  logic [6:0]       r_pprev;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0]    w_dest;
  logic [6:0]    w_entry;
  logic          w_lu_hit;
  logic          w_shift;
  logic          w_bubble;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_stall_inc;
  logic          w_flush_inc;

  assign w_dest  = dec_wsel ? dec_rb : dec_ra;
  assign w_entry = {dec_valid & dec_we, dec_wsel, w_dest, dec_data_sel};

  // SP (r3) is excluded: its value is never sourced from a load.
  assign w_lu_hit = dec_valid && r_prev[6] && (r_prev[2:0] == 3'b000) &&
                    (r_prev[4:3] != 2'b11) &&
                    ((dec_reads_a && (dec_ra == r_prev[4:3])) ||
                     (dec_reads_b && (dec_rb == r_prev[4:3])));

  always_comb begin
    stall       = 1'b0;
    flush       = 1'b0;
    w_shift     = 1'b1;
    w_bubble    = 1'b1;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (ext_hold) begin
      stall   = 1'b1;
      w_shift = 1'b0;
    end else if (branch_taken) begin
      flush       = 1'b1;
      w_flush_inc = 1'b1;
      w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      w_cnt_nxt   = FL_LOAD;
    end else begin
      case (r_state)
        ST_LU: begin
          stall = 1'b1;
          if (r_cnt == '0) w_state_nxt = ST_RUN;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
        ST_FLUSH: begin
          flush = 1'b1;
          if (r_cnt == '0) w_state_nxt = ST_RUN;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
        default: begin
          w_state_nxt = ST_RUN;
          if (w_lu_hit) begin
            stall       = 1'b1;
            w_stall_inc = 1'b1;
            w_state_nxt = (LU_STALLS > 1) ? ST_LU : ST_RUN;
            w_cnt_nxt   = LU_LOAD;
          end else begin
            w_bubble = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_pprev     <= '0;
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_shift) begin
      r_pprev <= r_prev;
      r_prev  <= w_bubble ? 7'b0 : w_entry;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign prev_we        = r_prev[6];
  assign prev_wsel      = r_prev[5];
  assign prev_waddr     = r_prev[4:3];
  assign prev_data_sel  = r_prev[2:0];
  assign pprev_we       = r_pprev[6];
  assign pprev_wsel     = r_pprev[5];
  assign pprev_waddr    = r_pprev[4:3];
  assign pprev_data_sel = r_pprev[2:0];
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_hazard_history_unit.sv
// Bench for hazard_history_unit: two configurations driven in lockstep and compared
// against a bubble-budget reference model.
module tb_hazard_history_unit;

  logic clk, rst_n, ext_hold, dec_valid, dec_we, dec_wsel, dec_reads_a, dec_reads_b;
  logic branch_taken;
  logic [1:0] dec_ra, dec_rb;
  logic [2:0] dec_data_sel;

  logic a_pwe, a_ppwe, a_pws, a_ppws, a_stall, a_flush;
  logic [1:0] a_pwa, a_ppwa;
  logic [2:0] a_pds, a_ppds;
  logic [15:0] a_scnt, a_fcnt;
  logic b_pwe, b_ppwe, b_pws, b_ppws, b_stall, b_flush;
  logic [1:0] b_pwa, b_ppwa;
  logic [2:0] b_pds, b_ppds;
  logic [2:0] b_scnt, b_fcnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_history_unit dut_a (
    .clk(clk), .rst_n(rst_n), .ext_hold(ext_hold), .dec_valid(dec_valid), .dec_we(dec_we),
    .dec_wsel(dec_wsel), .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_data_sel(dec_data_sel),
    .dec_reads_a(dec_reads_a), .dec_reads_b(dec_reads_b), .branch_taken(branch_taken),
    .prev_we(a_pwe), .pprev_we(a_ppwe), .prev_wsel(a_pws), .pprev_wsel(a_ppws),
    .prev_waddr(a_pwa), .pprev_waddr(a_ppwa), .prev_data_sel(a_pds), .pprev_data_sel(a_ppds),
    .stall(a_stall), .flush(a_flush), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  hazard_history_unit #(.LU_STALLS(3), .FLUSH_CYCLES(3), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ext_hold(ext_hold), .dec_valid(dec_valid), .dec_we(dec_we),
    .dec_wsel(dec_wsel), .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_data_sel(dec_data_sel),
    .dec_reads_a(dec_reads_a), .dec_reads_b(dec_reads_b), .branch_taken(branch_taken),
    .prev_we(b_pwe), .pprev_we(b_ppwe), .prev_wsel(b_pws), .pprev_wsel(b_ppws),
    .prev_waddr(b_pwa), .pprev_waddr(b_ppwa), .prev_data_sel(b_pds), .pprev_data_sel(b_ppds),
    .stall(b_stall), .flush(b_flush), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per configuration, history entries plus the number of
  // stall/flush bubbles still owed.
  int         m_lu [2] = '{1, 3};
  int         m_fl [2] = '{2, 3};
  int         m_max[2] = '{65535, 7};
  logic [6:0] m_prev[2], m_pprev[2];
  int         m_srem[2], m_frem[2], m_scnt[2], m_fcnt[2];
  bit         e_stall[2], e_flush[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = '0; m_pprev[d] = '0; m_srem[d] = 0; m_frem[d] = 0;
      m_scnt[d] = 0;  m_fcnt[d] = 0;
    end
  endtask

  // Evaluates the cycle; with commit set, also applies the clock edge.
  task automatic model_step(input int d, input bit commit);
    logic [1:0] dest;
    logic [6:0] ent;
    bit hit, shift, bub;
    dest = dec_wsel ? dec_rb : dec_ra;
    ent  = {dec_valid & dec_we, dec_wsel, dest, dec_data_sel};
    hit  = dec_valid && m_prev[d][6] && m_prev[d][2:0] == 3'd0 && m_prev[d][4:3] != 2'd3 &&
           ((dec_reads_a && dec_ra == m_prev[d][4:3]) ||
            (dec_reads_b && dec_rb == m_prev[d][4:3]));
    e_stall[d] = 0; e_flush[d] = 0; shift = 1; bub = 1;
    if (ext_hold) begin
      e_stall[d] = 1; shift = 0;
    end else if (branch_taken) begin
      e_flush[d] = 1;
      if (commit) begin
        m_fcnt[d] = (m_fcnt[d] < m_max[d]) ? m_fcnt[d] + 1 : m_fcnt[d];
        m_frem[d] = m_fl[d] - 1; m_srem[d] = 0;
      end
    end else if (m_frem[d] > 0) begin
      e_flush[d] = 1;
      if (commit) m_frem[d]--;
    end else if (m_srem[d] > 0) begin
      e_stall[d] = 1;
      if (commit) m_srem[d]--;
    end else if (hit) begin
      e_stall[d] = 1;
      if (commit) begin
        m_scnt[d] = (m_scnt[d] < m_max[d]) ? m_scnt[d] + 1 : m_scnt[d];
        m_srem[d] = m_lu[d] - 1;
      end
    end else begin
      bub = 0;
    end
    if (commit && shift) begin
      m_pprev[d] = m_prev[d];
      m_prev[d]  = bub ? 7'd0 : ent;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    for (int d = 0; d < 2; d++) model_step(d, 0);
    chk("a_stall", 32'(a_stall), 32'(e_stall[0]));
    chk("a_flush", 32'(a_flush), 32'(e_flush[0]));
    chk("b_stall", 32'(b_stall), 32'(e_stall[1]));
    chk("b_flush", 32'(b_flush), 32'(e_flush[1]));
  endtask

  task automatic chk_regs();
    chk("a_prev",  32'({a_pwe, a_pws, a_pwa, a_pds}),      32'(m_prev[0]));
    chk("a_pprev", 32'({a_ppwe, a_ppws, a_ppwa, a_ppds}),  32'(m_pprev[0]));
    chk("a_scnt",  32'(a_scnt), 32'(m_scnt[0]));
    chk("a_fcnt",  32'(a_fcnt), 32'(m_fcnt[0]));
    chk("b_prev",  32'({b_pwe, b_pws, b_pwa, b_pds}),      32'(m_prev[1]));
    chk("b_pprev", 32'({b_ppwe, b_ppws, b_ppwa, b_ppds}),  32'(m_pprev[1]));
    chk("b_scnt",  32'(b_scnt), 32'(m_scnt[1]));
    chk("b_fcnt",  32'(b_fcnt), 32'(m_fcnt[1]));
  endtask

  // Inputs are driven 1 time unit after the rising edge; this checks and advances.
  task automatic cycle();
    #2;
    chk_comb();
    for (int d = 0; d < 2; d++) model_step(d, 1);
    @(posedge clk);
    #1;
    chk_regs();
  endtask

  task automatic drive(input bit v, input bit we, input bit ws, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [2:0] ds, input bit rda,
                       input bit rdb, input bit br, input bit hold);
    dec_valid = v; dec_we = we; dec_wsel = ws; dec_ra = ra; dec_rb = rb;
    dec_data_sel = ds; dec_reads_a = rda; dec_reads_b = rdb;
    branch_taken = br; ext_hold = hold;
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_comb();
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #3;
    chk_comb();
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through of an ADD writing r1 from the ALU
    drive(1, 1, 0, 2'd1, 2'd0, 3'd1, 0, 0, 0, 0);
    cycle();
    chk("pass_prev", 32'({a_pwe, a_pws, a_pwa, a_pds}), 32'h49);
    idle();
    cycle();
    chk("pass_pprev", 32'({a_ppwe, a_ppws, a_ppwa, a_ppds}), 32'h49);

    // Load r2, then a reader of rb=2; hold mid LU_STALL of the 3-stall config
    drive(1, 1, 0, 2'd2, 2'd0, 3'd0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 0, 2'd1, 2'd2, 3'd1, 1, 1, 0, 0);
    cycle();
    chk("lu_bubble", 32'(a_pwe), 32'd0);
    chk("lu_scnt", 32'(a_scnt), 32'd1);
    chk("lu_pprev_addr", 32'(a_ppwa), 32'd2);
    ext_hold = 1'b1;
    repeat (3) cycle();
    ext_hold = 1'b0;
    repeat (3) cycle();

    // SP exemption: load into r3 then read r3
    drive(1, 1, 0, 2'd3, 2'd0, 3'd0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 0, 2'd3, 2'd3, 3'd1, 1, 1, 0, 0);
    #2;
    chk("sp_no_stall", 32'(a_stall), 32'd0);
    cycle();

    // Branch flush
    idle();
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    repeat (3) cycle();

    // Load-use and branch in the same cycle
    drive(1, 1, 0, 2'd1, 2'd0, 3'd0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 0, 2'd1, 2'd0, 3'd1, 1, 0, 1, 0);
    #2;
    chk("simul_stall", 32'(a_stall), 32'd0);
    chk("simul_flush", 32'(a_flush), 32'd1);
    cycle();
    idle();
    repeat (3) cycle();

    // Asynchronous reset in the middle of a flush
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    reset_pulse();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
            2'($urandom), 2'($urandom),
            ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 4)),
            1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0);
      cycle();
    end

    // Saturation of the narrow stall counter
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 2'd0, 2'd0, 3'd1, 1, 0, 0, 0);
      repeat (3) cycle();
    end
    chk("b_scnt_sat", 32'(b_scnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
